// File: rtl/time_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : time_set_ctrl                                                |
// | Description : Mode/set controller for the watch time counters. Two         |
// |               push-buttons step RUN -> SET_HOUR -> SET_MIN -> COMMIT.      |
// |               The watch is frozen while editing and receives a one-cycle   |
// |               parallel load of the edited time on COMMIT.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_i          system clock                                              |
// |   rst_ni         asynchronous active-low reset                             |
// |   en_1hz_i       one-clock-wide 1 Hz tick                                  |
// |   btn_mode_i     mode button level (debounced, asynchronous to clk_i)      |
// |   btn_up_i       increment button level (debounced, asynchronous)          |
// |   hour_10_i ..   live BCD time digits from the watch                       |
// |   min_1_i                                                                  |
// |   run_en_o       1 = watch counts, 0 = watch frozen                        |
// |   load_o         one-cycle strobe: watch takes ld_* and clears seconds     |
// |   ld_*_o         edited time digits (meaningful whenever mode != RUN)      |
// |   mode_o         00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 COMMIT                |
// |   blank_hour_o   blank the hour digits (blink while editing hours)         |
// |   blank_min_o    blank the minute digits (blink while editing minutes)     |
// +----------------------------------------------------------------------------+
module time_set_ctrl #(
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_1hz_i,
  input  logic       btn_mode_i,
  input  logic       btn_up_i,
  input  logic [1:0] hour_10_i,
  input  logic [3:0] hour_1_i,
  input  logic [2:0] min_10_i,
  input  logic [3:0] min_1_i,
  output logic       run_en_o,
  output logic       load_o,
  output logic [1:0] ld_hour_10_o,
  output logic [3:0] ld_hour_1_o,
  output logic [2:0] ld_min_10_o,
  output logic [3:0] ld_min_1_o,
  output logic [1:0] mode_o,
  output logic       blank_hour_o,
  output logic       blank_min_o
);

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_SET_HOUR = 2'b01;
  localparam logic [1:0] S_SET_MIN  = 2'b10;
  localparam logic [1:0] S_COMMIT   = 2'b11;

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TICK_W  = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  localparam logic [RPT_W-1:0]  C_DLY       = RPT_W'(REPEAT_DLY);
  localparam logic [RPT_W-1:0]  C_PER       = RPT_W'(REPEAT_PER);
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TIMEOUT_S - 1);

  // Button synchronisers and edge detectors
  logic mode_meta_q, mode_sync_q, mode_prev_q;
  logic up_meta_q, up_sync_q, up_prev_q;
  logic mode_edge, up_edge;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      mode_prev_q <= 1'b0;
      up_meta_q   <= 1'b0;
      up_sync_q   <= 1'b0;
      up_prev_q   <= 1'b0;
    end else begin
      mode_meta_q <= btn_mode_i;
      mode_sync_q <= mode_meta_q;
      mode_prev_q <= mode_sync_q;
      up_meta_q   <= btn_up_i;
      up_sync_q   <= up_meta_q;
      up_prev_q   <= up_sync_q;
    end
  end

  assign mode_edge = mode_sync_q & ~mode_prev_q;
  assign up_edge   = up_sync_q & ~up_prev_q;

  // State and datapath registers
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        ld_hour_10_q, ld_hour_10_d;
  logic [3:0]        ld_hour_1_q, ld_hour_1_d;
  logic [2:0]        ld_min_10_q, ld_min_10_d;
  logic [3:0]        ld_min_1_q, ld_min_1_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              rpt_active_q, rpt_active_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              blink_q, blink_d;

  logic set_q, set_d, state_chg;
  logic rpt_fire, timeout_hit, up_evt;
  logic hour_ok, min_ok;

  assign set_q     = (mode_q == S_SET_HOUR) || (mode_q == S_SET_MIN);
  assign set_d     = (mode_d == S_SET_HOUR) || (mode_d == S_SET_MIN);
  assign state_chg = (mode_d != mode_q);

  // First repeat after REPEAT_DLY held cycles, then one every REPEAT_PER
  assign rpt_fire = up_sync_q && set_q &&
                    (rpt_cnt_q == (rpt_active_q ? C_PER : C_DLY));

  // A button edge in the same cycle restarts the idle count instead
  assign timeout_hit = set_q && en_1hz_i && (tick_q == C_TICK_LAST) &&
                       !mode_edge && !up_edge;

  assign up_evt = up_edge | rpt_fire;

  assign hour_ok = (hour_1_i <= 4'd9) &&
                   ((hour_10_i < 2'd2) || ((hour_10_i == 2'd2) && (hour_1_i <= 4'd3)));
  assign min_ok  = (min_10_i <= 3'd5) && (min_1_i <= 4'd9);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= S_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // FSM: next state (mode edge has priority over timeout)
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      S_RUN:      if (mode_edge) mode_d = S_SET_HOUR;
      S_SET_HOUR: begin
        if (mode_edge)        mode_d = S_SET_MIN;
        else if (timeout_hit) mode_d = S_RUN;
      end
      S_SET_MIN: begin
        if (mode_edge)        mode_d = S_COMMIT;
        else if (timeout_hit) mode_d = S_RUN;
      end
      default:    mode_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_en_o     = (mode_q == S_RUN);
    load_o       = (mode_q == S_COMMIT);
    mode_o       = mode_q;
    blank_hour_o = blink_q && (mode_q == S_SET_HOUR);
    blank_min_o  = blink_q && (mode_q == S_SET_MIN);
    ld_hour_10_o = ld_hour_10_q;
    ld_hour_1_o  = ld_hour_1_q;
    ld_min_10_o  = ld_min_10_q;
    ld_min_1_o   = ld_min_1_q;
  end

  // Datapath next-state
  always_comb begin
    ld_hour_10_d = ld_hour_10_q;
    ld_hour_1_d  = ld_hour_1_q;
    ld_min_10_d  = ld_min_10_q;
    ld_min_1_d   = ld_min_1_q;

    if ((mode_q == S_RUN) && mode_edge) begin
      ld_hour_10_d = hour_ok ? hour_10_i : 2'd0;
      ld_hour_1_d  = hour_ok ? hour_1_i  : 4'd0;
      ld_min_10_d  = min_ok  ? min_10_i  : 3'd0;
      ld_min_1_d   = min_ok  ? min_1_i   : 4'd0;
    end else if ((mode_q == S_SET_HOUR) && !state_chg && up_evt) begin
      if ((ld_hour_10_q == 2'd2) && (ld_hour_1_q == 4'd3)) begin
        ld_hour_10_d = 2'd0;
        ld_hour_1_d  = 4'd0;
      end else if (ld_hour_1_q == 4'd9) begin
        ld_hour_10_d = ld_hour_10_q + 2'd1;
        ld_hour_1_d  = 4'd0;
      end else begin
        ld_hour_1_d  = ld_hour_1_q + 4'd1;
      end
    end else if ((mode_q == S_SET_MIN) && !state_chg && up_evt) begin
      if (ld_min_1_q == 4'd9) begin
        ld_min_1_d  = 4'd0;
        ld_min_10_d = (ld_min_10_q == 3'd5) ? 3'd0 : ld_min_10_q + 3'd1;
      end else begin
        ld_min_1_d  = ld_min_1_q + 4'd1;
      end
    end

    // Hold counter restarts from 1 after each repeat so the period counts from the fire
    rpt_cnt_d    = rpt_cnt_q;
    rpt_active_d = rpt_active_q;
    if (!up_sync_q || !set_q || state_chg) begin
      rpt_cnt_d    = '0;
      rpt_active_d = 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt_d    = RPT_W'(1);
      rpt_active_d = 1'b1;
    end else begin
      rpt_cnt_d    = rpt_cnt_q + RPT_W'(1);
    end

    tick_d = tick_q;
    if (!set_q || state_chg || mode_edge || up_edge) begin
      tick_d = '0;
    end else if (en_1hz_i) begin
      tick_d = tick_q + TICK_W'(1);
    end

    // Blink only lives inside SET states; leaving them forces it low
    blink_d = set_d ? (blink_q ^ (en_1hz_i & set_q)) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_hour_10_q <= 2'd0;
      ld_hour_1_q  <= 4'd0;
      ld_min_10_q  <= 3'd0;
      ld_min_1_q   <= 4'd0;
      rpt_cnt_q    <= '0;
      rpt_active_q <= 1'b0;
      tick_q       <= '0;
      blink_q      <= 1'b0;
    end else begin
      ld_hour_10_q <= ld_hour_10_d;
      ld_hour_1_q  <= ld_hour_1_d;
      ld_min_10_q  <= ld_min_10_d;
      ld_min_1_q   <= ld_min_1_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_active_q <= rpt_active_d;
      tick_q       <= tick_d;
      blink_q      <= blink_d;
    end
  end

endmodule
`default_nettype wire
